usb_tx_phy: RTL and testbench



---
 rtl/usb_pkg.sv | 30 +++
 rtl/usb_tx_bitenc.sv | 34 +++
 rtl/usb_tx_phy.sv | 130 +++++++++++++
 tb/tb_usb_tx_phy.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB transmit PHY.
// Line polarity follows USB_TX_LOW_SPEED_EN (defined: low-speed J/K, undefined: full-speed).
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    localparam logic [7:0] USB_SYNC        = 8'h80;
    localparam int         USB_STUFF_LIMIT = 6;
    localparam int         EOP_SE0_BITS    = 2;
    localparam int         EOP_J_BITS      = 1;

`ifdef USB_TX_LOW_SPEED_EN
    localparam logic J_DP = 1'b0;
    localparam logic J_DN = 1'b1;
    localparam logic K_DP = 1'b1;
    localparam logic K_DN = 1'b0;
`else
    localparam logic J_DP = 1'b1;
    localparam logic J_DN = 1'b0;
    localparam logic K_DP = 1'b0;
    localparam logic K_DN = 1'b1;
`endif

endpackage

// File: rtl/usb_tx_bitenc.sv
// usb_tx_bitenc: NRZI level tracking and bit-stuff detection for the serial stream.
// nrzi is the line level (1 = J) for the bit presented now; stuff flags that a 0 must be inserted next.
module usb_tx_bitenc
    import usb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic nrzi,
    output logic stuff
);

    logic       lvl;
    logic [2:0] ones;

    assign nrzi  = bit_in ? lvl : ~lvl;
    assign stuff = ones == 3'(USB_STUFF_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl  <= 1'b1;
            ones <= 3'd0;
        end else if (clear) begin
            lvl  <= 1'b1;
            ones <= 3'd0;
        end else if (en) begin
            lvl  <= nrzi;
            ones <= bit_in ? ones + 3'd1 : 3'd0;
        end
    end

endmodule

// File: rtl/usb_tx_phy.sv
// usb_tx_phy: USB transmit PHY -- SYNC, LSB-first data, bit stuffing, NRZI and EOP onto D+/D-.
// USB_TX_LOW_SPEED_EN selects low-speed J/K polarity (see usb_pkg).
module usb_tx_phy
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       d_p,
    output logic       d_n,
    output logic       d_oe
);

    localparam int         CW     = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] J_LINE = {J_DP, J_DN};
    localparam logic [1:0] K_LINE = {K_DP, K_DN};

    tx_state_t      state, state_n;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx, idx_n;
    logic [7:0]     sr, sr_n;
    logic           ready_n, oe_n, dp_n, dn_n;
    logic           emit, bit_out, nrzi, stuff, bit_en;

    assign bit_en = cnt == CW'(CLKS_PER_BIT - 1);

    usb_tx_bitenc u_enc (
        .clk    (clk),
        .reset  (reset),
        .clear  (usb_reset || state == ST_EOP_SE0),
        .en     (emit),
        .bit_in (bit_out),
        .nrzi   (nrzi),
        .stuff  (stuff)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        sr_n    = sr;
        ready_n = 1'b0;
        oe_n    = d_oe;
        emit    = 1'b0;
        bit_out = 1'b0;
        unique case (state)
            ST_IDLE: if (tx_valid) begin
                state_n = ST_SYNC;
                sr_n    = USB_SYNC;
                idx_n   = 3'd0;
                emit    = 1'b1;
                bit_out = USB_SYNC[0];
                oe_n    = 1'b1;
            end
            ST_SYNC, ST_DATA: if (bit_en) begin
                emit = 1'b1;
                // a pending stuff bit goes out before the byte index moves on
                if (stuff) begin
                    bit_out = 1'b0;
                end else if (idx != 3'd7) begin
                    idx_n   = idx + 3'd1;
                    bit_out = sr[idx + 3'd1];
                end else if (tx_valid) begin
                    state_n = ST_DATA;
                    sr_n    = tx_data;
                    idx_n   = 3'd0;
                    ready_n = 1'b1;
                    bit_out = tx_data[0];
                end else begin
                    emit    = 1'b0;
                    state_n = ST_EOP_SE0;
                    idx_n   = 3'd0;
                end
            end
            ST_EOP_SE0: if (bit_en) begin
                idx_n = idx + 3'd1;
                if (idx == 3'(EOP_SE0_BITS - 1)) begin
                    state_n = ST_EOP_J;
                    idx_n   = 3'd0;
                end
            end
            ST_EOP_J: if (bit_en) begin
                idx_n = idx + 3'd1;
                if (idx == 3'(EOP_J_BITS - 1)) begin
                    state_n = ST_IDLE;
                    idx_n   = 3'd0;
                    oe_n    = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (usb_reset) begin
            state_n = ST_IDLE;
            idx_n   = 3'd0;
            ready_n = 1'b0;
            oe_n    = 1'b0;
            emit    = 1'b0;
        end
        {dp_n, dn_n} = (state_n == ST_EOP_SE0) ? 2'b00 :
                       (state_n == ST_IDLE || state_n == ST_EOP_J) ? J_LINE :
                       emit ? (nrzi ? J_LINE : K_LINE) : {d_p, d_n};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            idx      <= 3'd0;
            sr       <= 8'h00;
            tx_ready <= 1'b0;
            d_oe     <= 1'b0;
            d_p      <= J_DP;
            d_n      <= J_DN;
        end else begin
            state    <= state_n;
            cnt      <= (state == ST_IDLE || usb_reset || bit_en) ? '0 : cnt + 1'b1;
            idx      <= idx_n;
            sr       <= sr_n;
            tx_ready <= ready_n;
            d_oe     <= oe_n;
            d_p      <= dp_n;
            d_n      <= dn_n;
        end
    end

endmodule

// File: tb/tb_usb_tx_phy.sv
// tb_usb_tx_phy: scoreboard bench for usb_tx_phy; a reference model queues every expected line symbol.
// Honours USB_TX_LOW_SPEED_EN for J/K polarity.
module tb_usb_tx_phy;

    localparam int CB = 4;
`ifdef USB_TX_LOW_SPEED_EN
    localparam logic J_DP = 1'b0;
    localparam logic J_DN = 1'b1;
`else
    localparam logic J_DP = 1'b1;
    localparam logic J_DN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, usb_reset, tx_valid, tx_ready, d_p, d_n, d_oe;
    logic [7:0] tx_data;

    logic [7:0] pkt[$];
    logic [3:0] exp_q[$];
    logic       m_lvl;
    int         m_ones;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         rdy_cnt = 0;

    usb_tx_phy #(.CLKS_PER_BIT(CB)) dut (
        .clk       (clk),
        .reset     (reset),
        .usb_reset (usb_reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .d_p       (d_p),
        .d_n       (d_n),
        .d_oe      (d_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tx_ready) rdy_cnt <= rdy_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] sym(input logic is_j);
        return is_j ? {J_DP, J_DN} : {J_DN, J_DP};
    endfunction

    // symbol = {d_oe, d_p, d_n, tx_ready}
    task automatic push_bit(input logic bv, input logic rdy);
        if (!bv) m_lvl = ~m_lvl;
        m_ones = bv ? m_ones + 1 : 0;
        exp_q.push_back({1'b1, sym(m_lvl), rdy});
        if (m_ones == 6) begin
            m_lvl  = ~m_lvl;
            m_ones = 0;
            exp_q.push_back({1'b1, sym(m_lvl), 1'b0});
        end
    endtask

    task automatic build_exp();
        logic [7:0] s;
        exp_q.delete();
        m_lvl  = 1'b1;
        m_ones = 0;
        s = 8'h80;
        for (int k = 0; k < 8; k++) push_bit(s[k], 1'b0);
        foreach (pkt[i]) for (int k = 0; k < 8; k++) push_bit(pkt[i][k], k == 0);
        exp_q.push_back({1'b1, 2'b00, 1'b0});
        exp_q.push_back({1'b1, 2'b00, 1'b0});
        exp_q.push_back({1'b1, J_DP, J_DN, 1'b0});
    endtask

    task automatic sie_drive();
        int i = 1;
        if (pkt.size() == 0) begin
            repeat (2) @(negedge clk);
            tx_valid = 1'b0;
            return;
        end
        for (int c = 0; c < 4000 && tx_valid; c++) begin
            @(negedge clk);
            if (tx_ready) begin
                if (i < pkt.size()) begin
                    tx_data = pkt[i];
                    i++;
                end else tx_valid = 1'b0;
            end
        end
        if (tx_valid) begin
            chk("drv_timeout", 32'd0, 32'd1);
            tx_valid = 1'b0;
        end
    endtask

    task automatic monitor(input string tag);
        logic [3:0] e;
        @(posedge clk);
        #1;
        chk({tag, "_lat"}, 32'(d_oe), 32'd1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, 32'({d_oe, d_p, d_n, tx_ready}), 32'(e));
            repeat (CB) @(posedge clk);
            #1;
        end
        chk({tag, "_end"}, 32'({d_oe, d_p, d_n}), 32'({1'b0, J_DP, J_DN}));
    endtask

    task automatic run_pkt(input string tag);
        int r0;
        build_exp();
        r0 = rdy_cnt;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = (pkt.size() != 0) ? pkt[0] : 8'h00;
        fork
            sie_drive();
            monitor(tag);
        join
        repeat (2) @(negedge clk);
        chk({tag, "_rdy"}, 32'(rdy_cnt - r0), 32'(pkt.size()));
    endtask

    initial begin
        int nr, i, r0, bad;
        reset = 1'b1; usb_reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst", 32'({d_oe, d_p, d_n, tx_ready}), 32'({1'b0, J_DP, J_DN, 1'b0}));
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);

        pkt = '{8'hA5};        run_pkt("a5");
        pkt = '{8'hFF, 8'hFF}; run_pkt("ff");
        pkt = '{8'h00, 8'h3F}; run_pkt("3f");
        pkt.delete();          run_pkt("sync");
        pkt.delete();
        for (int k = 0; k < 4; k++) pkt.push_back(8'($urandom_range(0, 255)));
        run_pkt("rnd");

        // bus reset in the middle of the second byte
        pkt = '{8'h11, 8'h22, 8'h33};
        @(negedge clk);
        tx_valid = 1'b1; tx_data = pkt[0];
        i = 1; nr = 0;
        for (int c = 0; c < 400 && nr < 2; c++) begin
            @(negedge clk);
            if (tx_ready) begin
                nr++;
                tx_data = pkt[i];
                i++;
            end
        end
        chk("ur_rdy2", 32'(nr), 32'd2);
        repeat (10) @(negedge clk);
        usb_reset = 1'b1;
        r0 = rdy_cnt;
        @(posedge clk);
        #1;
        chk("ur_oe", 32'({d_oe, d_p, d_n, tx_ready}), 32'({1'b0, J_DP, J_DN, 1'b0}));
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (d_oe || tx_ready || (!d_p && !d_n)) bad++;
        end
        chk("ur_quiet", 32'(bad), 32'd0);
        @(negedge clk);
        usb_reset = 1'b0; tx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ur_idle", 32'(d_oe), 32'd0);
        chk("ur_nordy", 32'(rdy_cnt - r0), 32'd0);
        pkt = '{8'h33}; run_pkt("after_ur");

        // async reset during EOP SE0
        pkt = '{8'hA5};
        @(negedge clk);
        tx_valid = 1'b1; tx_data = pkt[0];
        sie_drive();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (d_oe && !d_p && !d_n) break;
        end
        chk("se0_seen", 32'(d_oe & ~d_p & ~d_n), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst", 32'({d_oe, d_p, d_n, tx_ready}), 32'({1'b0, J_DP, J_DN, 1'b0}));
        @(negedge clk) reset = 1'b0;
        pkt = '{8'h5A, 8'hC3}; run_pkt("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
